// File: rtl/dma_l2_range_guard_pkg.sv
// Shared types for the DMA->L2 range guard: AXI channel structs, FSM states, range check helper.
package dma_l2_range_guard_pkg;

  localparam int unsigned AXI_AW = 32;
  localparam int unsigned AXI_DW = 64;
  localparam int unsigned AXI_IW = 4;
  localparam int unsigned AXI_UW = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DRAIN, W_BRESP} w_state_e;
  typedef enum logic       {R_IDLE, R_ERR} r_state_e;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [AXI_AW-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [AXI_UW-1:0] user;
  } axi_ax_t;

  typedef struct packed {
    logic [AXI_DW-1:0]   data;
    logic [AXI_DW/8-1:0] strb;
    logic                last;
    logic [AXI_UW-1:0]   user;
  } axi_w_t;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [1:0]        resp;
    logic [AXI_UW-1:0] user;
  } axi_b_t;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [AXI_DW-1:0] data;
    logic [1:0]        resp;
    logic              last;
    logic [AXI_UW-1:0] user;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   r_valid;
    axi_r_t r;
  } axi_resp_t;

  // Last byte computed 9 bits wider than the address so a burst near the top cannot wrap.
  function automatic logic burst_in_range(input logic [63:0] addr, input logic [7:0] len,
                                          input logic [2:0] size, input logic [63:0] start_a,
                                          input logic [63:0] end_a);
    logic [72:0] last;
    last = {9'b0, addr} + ((73'(len) + 73'd1) << size) - 73'd1;
    return (addr >= start_a) && (last < {9'b0, end_a});
  endfunction

endpackage

// File: rtl/dma_l2_range_guard_cnt.sv
// Up/down outstanding-transaction counter, clamped to [0, MaxCnt], with full/empty flags.
module dma_l2_range_guard_cnt #(
  parameter int unsigned MaxCnt = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);
  localparam int unsigned CntW = $clog2(MaxCnt + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (inc && !dec && cnt_q != CntW'(MaxCnt)) begin
      cnt_q <= cnt_q + CntW'(1);
    end else if (dec && !inc && cnt_q != '0) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign full  = (cnt_q == CntW'(MaxCnt));
  assign empty = (cnt_q == '0);
endmodule

// File: rtl/dma_l2_range_guard.sv
// Range guard between DMA NoC and L2: forwards in-range AXI bursts, terminates others with SLVERR.
// Optional rejected-burst counter: define DMA_L2_RANGE_GUARD_ERR_CNT_EN.
module dma_l2_range_guard
  import dma_l2_range_guard_pkg::*;
#(
  parameter int unsigned AddrWidth = AXI_AW,
  parameter int unsigned DataWidth = AXI_DW,
  parameter int unsigned IdWidth   = AXI_IW,
  parameter int unsigned UserWidth = AXI_UW,
  parameter int unsigned MaxTxns   = 8,
  parameter type         req_t     = axi_req_t,
  parameter type         resp_t    = axi_resp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] l2_start_addr_i,
  input  logic [AddrWidth-1:0] l2_end_addr_i,
  input  req_t                 slv_req_i,
  output resp_t                slv_resp_o,
  output req_t                 mst_req_o,
  input  resp_t                mst_resp_i,
  output logic [15:0]          err_cnt_o
);
  localparam int unsigned PtrW = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic aw_ok, ar_ok;
  logic wcnt_full, wcnt_empty, rcnt_full, rcnt_empty;
  logic wr_room, bad_aw_ok, bad_ar_ok;
  logic aw_fwd, aw_bad_acc, ar_fwd, ar_bad_acc;
  logic w_ready, w_hs, b_mst_hs, r_mst_last_hs, r_err_hs, r_err_last;

  logic [IdWidth-1:0] w_id_q, r_id_q;
  logic [7:0]         r_len_q, r_beat_q;

  // W-route FIFO: 1 = beats go to L2, 0 = beats are drained locally.
  logic [MaxTxns-1:0] route_q;
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]      fill_q;
  logic               fifo_empty, fifo_full, fifo_head, fifo_push, fifo_pop;

  assign aw_ok = burst_in_range(64'(slv_req_i.aw.addr), slv_req_i.aw.len, slv_req_i.aw.size,
                                64'(l2_start_addr_i), 64'(l2_end_addr_i));
  assign ar_ok = burst_in_range(64'(slv_req_i.ar.addr), slv_req_i.ar.len, slv_req_i.ar.size,
                                64'(l2_start_addr_i), 64'(l2_end_addr_i));

  assign fifo_empty = (fill_q == '0);
  assign fifo_full  = (fill_q == (PtrW+1)'(MaxTxns));
  assign fifo_head  = route_q[rd_ptr_q];

  assign wr_room    = !wcnt_full && !fifo_full;
  // Error B may only go out when nothing older is in flight, keeping per-ID B order.
  assign bad_aw_ok  = (w_state_q == W_IDLE) && wcnt_empty && fifo_empty;
  assign bad_ar_ok  = (r_state_q == R_IDLE) && rcnt_empty;

  assign aw_fwd     = slv_req_i.aw_valid && aw_ok && wr_room && mst_resp_i.aw_ready;
  assign aw_bad_acc = slv_req_i.aw_valid && !aw_ok && bad_aw_ok;
  assign ar_fwd     = slv_req_i.ar_valid && ar_ok && !rcnt_full && mst_resp_i.ar_ready;
  assign ar_bad_acc = slv_req_i.ar_valid && !ar_ok && bad_ar_ok;

  assign w_ready    = !fifo_empty && (fifo_head ? mst_resp_i.w_ready : (w_state_q == W_DRAIN));
  assign w_hs       = slv_req_i.w_valid && w_ready;
  assign fifo_push  = aw_fwd || aw_bad_acc;
  assign fifo_pop   = w_hs && slv_req_i.w.last;

  assign b_mst_hs      = mst_resp_i.b_valid && slv_req_i.b_ready && (w_state_q != W_BRESP);
  assign r_mst_last_hs = mst_resp_i.r_valid && slv_req_i.r_ready && (r_state_q != R_ERR)
                         && mst_resp_i.r.last;
  assign r_err_hs      = (r_state_q == R_ERR) && slv_req_i.r_ready;
  assign r_err_last    = (r_beat_q == r_len_q);

  dma_l2_range_guard_cnt #(.MaxCnt(MaxTxns)) i_wr_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .inc   (aw_fwd),
    .dec   (b_mst_hs),
    .full  (wcnt_full),
    .empty (wcnt_empty)
  );

  dma_l2_range_guard_cnt #(.MaxCnt(MaxTxns)) i_rd_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .inc   (ar_fwd),
    .dec   (r_mst_last_hs),
    .full  (rcnt_full),
    .empty (rcnt_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      route_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (fifo_push) begin
        route_q[wr_ptr_q] <= aw_ok;
        wr_ptr_q <= (wr_ptr_q == PtrW'(MaxTxns - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (fifo_pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(MaxTxns - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      if (fifo_push && !fifo_pop)      fill_q <= fill_q + (PtrW+1)'(1);
      else if (fifo_pop && !fifo_push) fill_q <= fill_q - (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      W_IDLE:  if (aw_bad_acc) w_state_d = W_DRAIN;
      W_DRAIN: if (fifo_pop) w_state_d = W_BRESP;
      W_BRESP: if (slv_req_i.b_ready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE:  if (ar_bad_acc) r_state_d = R_ERR;
      R_ERR:   if (r_err_hs && r_err_last) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_id_q   <= '0;
      r_id_q   <= '0;
      r_len_q  <= '0;
      r_beat_q <= '0;
    end else begin
      if (aw_bad_acc) w_id_q <= slv_req_i.aw.id;
      if (ar_bad_acc) begin
        r_id_q   <= slv_req_i.ar.id;
        r_len_q  <= slv_req_i.ar.len;
        r_beat_q <= '0;
      end else if (r_err_hs) begin
        r_beat_q <= r_beat_q + 8'd1;
      end
    end
  end

  always_comb begin
    mst_req_o  = slv_req_i;
    slv_resp_o = mst_resp_i;

    mst_req_o.aw_valid  = slv_req_i.aw_valid && aw_ok && wr_room;
    slv_resp_o.aw_ready = rst_ni && (aw_ok ? (mst_resp_i.aw_ready && wr_room) : bad_aw_ok);

    mst_req_o.w_valid  = slv_req_i.w_valid && !fifo_empty && fifo_head;
    slv_resp_o.w_ready = rst_ni && w_ready;

    mst_req_o.ar_valid  = slv_req_i.ar_valid && ar_ok && !rcnt_full;
    slv_resp_o.ar_ready = rst_ni && (ar_ok ? (mst_resp_i.ar_ready && !rcnt_full) : bad_ar_ok);

    if (w_state_q == W_BRESP) begin
      mst_req_o.b_ready  = 1'b0;
      slv_resp_o.b_valid = 1'b1;
      slv_resp_o.b.id    = w_id_q;
      slv_resp_o.b.resp  = RESP_SLVERR;
      slv_resp_o.b.user  = {UserWidth{1'b0}};
    end

    if (r_state_q == R_ERR) begin
      mst_req_o.r_ready  = 1'b0;
      slv_resp_o.r_valid = 1'b1;
      slv_resp_o.r.id    = r_id_q;
      slv_resp_o.r.data  = {DataWidth{1'b0}};
      slv_resp_o.r.resp  = RESP_SLVERR;
      slv_resp_o.r.last  = r_err_last;
      slv_resp_o.r.user  = {UserWidth{1'b0}};
    end
  end

`ifdef DMA_L2_RANGE_GUARD_ERR_CNT_EN
  logic [15:0] err_cnt_q;
  logic [16:0] err_sum;

  assign err_sum = {1'b0, err_cnt_q} + 17'(aw_bad_acc) + 17'(ar_bad_acc);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_cnt_q <= '0;
    else         err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_dma_l2_range_guard.sv
// Directed bench for dma_l2_range_guard: pass-through, SLVERR termination, ordering stalls, reset.
module tb_dma_l2_range_guard;
  import dma_l2_range_guard_pkg::*;

`ifdef DMA_L2_RANGE_GUARD_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] l2_start, l2_end;
  axi_req_t    slv_req, mst_req;
  axi_resp_t   slv_resp, mst_resp;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;

  dma_l2_range_guard #(
    .AddrWidth(32), .DataWidth(64), .IdWidth(4), .UserWidth(1), .MaxTxns(8),
    .req_t(axi_req_t), .resp_t(axi_resp_t)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .l2_start_addr_i(l2_start),
    .l2_end_addr_i  (l2_end),
    .slv_req_i      (slv_req),
    .slv_resp_o     (slv_resp),
    .mst_req_o      (mst_req),
    .mst_resp_i     (mst_resp),
    .err_cnt_o      (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic axi_ax_t ax(input logic [3:0] id, input logic [31:0] addr,
                                 input logic [7:0] len, input logic [2:0] size);
    ax = '0;
    ax.id = id; ax.addr = addr; ax.len = len; ax.size = size; ax.burst = 2'b01;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog time limit");
    $fatal(1, "timeout");
  end

  initial begin
    slv_req = '0; mst_resp = '0; rst_n = 1'b0;
    l2_start = 32'h1C00_0000; l2_end = 32'h1C10_0000;
    repeat (2) @(negedge clk);
    // readies seen by the NoC stay low in reset even with L2 ready
    slv_req.aw = ax(0, 32'h1C00_0000, 0, 3); slv_req.aw_valid = 1'b1;
    mst_resp.aw_ready = 1'b1;
    #1;
    chk("rst_aw_ready", 64'(slv_resp.aw_ready), 0);
    chk("rst_b_valid", 64'(slv_resp.b_valid), 0);
    chk("rst_r_valid", 64'(slv_resp.r_valid), 0);
    chk("rst_err_cnt", 64'(err_cnt), 0);
    slv_req = '0; mst_resp = '0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // 1: in-range write forwarded
    slv_req.aw = ax(1, 32'h1C00_0100, 3, 3); slv_req.aw_valid = 1'b1; mst_resp.aw_ready = 1'b1;
    #1;
    chk("t1_mst_aw_valid", 64'(mst_req.aw_valid), 1);
    chk("t1_mst_aw_addr", 64'(mst_req.aw.addr), 64'h1C00_0100);
    chk("t1_slv_aw_ready", 64'(slv_resp.aw_ready), 1);
    @(negedge clk); slv_req.aw_valid = 1'b0; mst_resp.aw_ready = 1'b0; mst_resp.w_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      slv_req.w_valid = 1'b1; slv_req.w.data = 64'hA0 + 64'(i); slv_req.w.last = (i == 3);
      #1;
      chk("t1_mst_w_valid", 64'(mst_req.w_valid), 1);
      chk("t1_mst_w_data", mst_req.w.data, 64'hA0 + 64'(i));
      @(negedge clk);
    end
    slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0;
    #1 chk("t1_w_held_no_aw", 64'(slv_resp.w_ready), 0);
    mst_resp.w_ready = 1'b0;
    mst_resp.b_valid = 1'b1; mst_resp.b.id = 4'd1; mst_resp.b.resp = RESP_OKAY; slv_req.b_ready = 1'b1;
    #1;
    chk("t1_b_valid", 64'(slv_resp.b_valid), 1);
    chk("t1_b_id", 64'(slv_resp.b.id), 1);
    chk("t1_b_resp", 64'(slv_resp.b.resp), 0);
    @(negedge clk); mst_resp.b_valid = 1'b0; slv_req.b_ready = 1'b0;

    // 2: write crossing the end address is terminated locally
    slv_req.aw = ax(5, 32'h1C0F_FFF8, 1, 3); slv_req.aw_valid = 1'b1; mst_resp.aw_ready = 1'b1;
    #1;
    chk("t2_mst_aw_valid", 64'(mst_req.aw_valid), 0);
    chk("t2_slv_aw_ready", 64'(slv_resp.aw_ready), 1);
    @(negedge clk); slv_req.aw_valid = 1'b0; mst_resp.aw_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      slv_req.w_valid = 1'b1; slv_req.w.last = (i == 1);
      #1;
      chk("t2_w_drop_ready", 64'(slv_resp.w_ready), 1);
      chk("t2_w_not_fwd", 64'(mst_req.w_valid), 0);
      @(negedge clk);
    end
    slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0;
    #1;
    chk("t2_b_valid", 64'(slv_resp.b_valid), 1);
    chk("t2_b_resp", 64'(slv_resp.b.resp), 2);
    chk("t2_b_id", 64'(slv_resp.b.id), 5);
    @(negedge clk);
    #1 chk("t2_b_hold", 64'(slv_resp.b_valid), 1);
    slv_req.b_ready = 1'b1;
    @(negedge clk); slv_req.b_ready = 1'b0;
    #1 chk("t2_b_done", 64'(slv_resp.b_valid), 0);

    // 3: out-of-range read answered with 8 SLVERR beats
    slv_req.ar = ax(7, 32'h0, 7, 3); slv_req.ar_valid = 1'b1; mst_resp.ar_ready = 1'b1;
    #1;
    chk("t3_mst_ar_valid", 64'(mst_req.ar_valid), 0);
    chk("t3_slv_ar_ready", 64'(slv_resp.ar_ready), 1);
    @(negedge clk); slv_req.ar_valid = 1'b0; mst_resp.ar_ready = 1'b0; slv_req.r_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t3_r_valid", 64'(slv_resp.r_valid), 1);
      chk("t3_r_resp", 64'(slv_resp.r.resp), 2);
      chk("t3_r_data", slv_resp.r.data, 0);
      chk("t3_r_id", 64'(slv_resp.r.id), 7);
      chk("t3_r_last", 64'(slv_resp.r.last), 64'(i == 7));
      @(negedge clk);
    end
    #1 chk("t3_r_done", 64'(slv_resp.r_valid), 0);
    slv_req.r_ready = 1'b0;

    // 4: bad AW waits for the outstanding good write with the same ID
    slv_req.aw = ax(2, 32'h1C00_0200, 0, 2); slv_req.aw_valid = 1'b1; mst_resp.aw_ready = 1'b1;
    #1 chk("t4_good_fwd", 64'(mst_req.aw_valid), 1);
    @(negedge clk); slv_req.aw_valid = 1'b0;
    slv_req.w_valid = 1'b1; slv_req.w.last = 1'b1; mst_resp.w_ready = 1'b1;
    #1 chk("t4_good_w", 64'(mst_req.w_valid), 1);
    @(negedge clk); slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0; mst_resp.w_ready = 1'b0;
    slv_req.aw = ax(2, 32'h2000_0000, 0, 2); slv_req.aw_valid = 1'b1;
    #1;
    chk("t4_bad_stall", 64'(slv_resp.aw_ready), 0);
    chk("t4_bad_not_fwd", 64'(mst_req.aw_valid), 0);
    @(negedge clk);
    #1 chk("t4_bad_stall2", 64'(slv_resp.aw_ready), 0);
    mst_resp.b_valid = 1'b1; mst_resp.b.id = 4'd2; mst_resp.b.resp = RESP_OKAY; slv_req.b_ready = 1'b1;
    #1;
    chk("t4_b1_resp", 64'(slv_resp.b.resp), 0);
    chk("t4_b1_stall", 64'(slv_resp.aw_ready), 0);
    @(negedge clk); mst_resp.b_valid = 1'b0;
    #1 chk("t4_bad_accept", 64'(slv_resp.aw_ready), 1);
    @(negedge clk); slv_req.aw_valid = 1'b0; mst_resp.aw_ready = 1'b0;
    slv_req.w_valid = 1'b1; slv_req.w.last = 1'b1;
    #1 chk("t4_drain_ready", 64'(slv_resp.w_ready), 1);
    @(negedge clk); slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0;
    #1;
    chk("t4_b2_resp", 64'(slv_resp.b.resp), 2);
    chk("t4_b2_id", 64'(slv_resp.b.id), 2);
    @(negedge clk); slv_req.b_ready = 1'b0;
    #1;
    chk("t4_b2_done", 64'(slv_resp.b_valid), 0);
    chk("t4_err_cnt", 64'(err_cnt), CNT_EN ? 64'd3 : 64'd0);

    // 5: read outstanding limit
    mst_resp.ar_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      slv_req.ar = ax(3, 32'h1C00_0000 + 32'(i * 8), 0, 3); slv_req.ar_valid = 1'b1;
      #1 chk("t5_ar_accept", 64'(slv_resp.ar_ready), 1);
      @(negedge clk);
    end
    #1;
    chk("t5_ar_full", 64'(slv_resp.ar_ready), 0);
    chk("t5_mst_ar_blocked", 64'(mst_req.ar_valid), 0);
    mst_resp.r_valid = 1'b1; mst_resp.r.last = 1'b1; mst_resp.r.id = 4'd3; slv_req.r_ready = 1'b1;
    #1;
    chk("t5_r_pass", 64'(slv_resp.r_valid), 1);
    chk("t5_ar_still_full", 64'(slv_resp.ar_ready), 0);
    @(negedge clk); mst_resp.r_valid = 1'b0; mst_resp.r.last = 1'b0; slv_req.r_ready = 1'b0;
    #1;
    chk("t5_ar_9th", 64'(slv_resp.ar_ready), 1);
    chk("t5_mst_ar_9th", 64'(mst_req.ar_valid), 1);
    @(negedge clk); slv_req.ar_valid = 1'b0; mst_resp.ar_ready = 1'b0;

    // 6: reset in the middle of a drain, then error counting
    slv_req.aw = ax(4, 32'h3000_0000, 3, 3); slv_req.aw_valid = 1'b1;
    #1 chk("t6_bad_aw", 64'(slv_resp.aw_ready), 1);
    @(negedge clk); slv_req.aw_valid = 1'b0;
    slv_req.w_valid = 1'b1; slv_req.w.last = 1'b0;
    #1 chk("t6_drain", 64'(slv_resp.w_ready), 1);
    chk("t6_err_cnt_pre", 64'(err_cnt), CNT_EN ? 64'd4 : 64'd0);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("t6_rst_w_ready", 64'(slv_resp.w_ready), 0);
    chk("t6_rst_b_valid", 64'(slv_resp.b_valid), 0);
    chk("t6_rst_err_cnt", 64'(err_cnt), 0);
    @(negedge clk); rst_n = 1'b1; slv_req.w_valid = 1'b0;
    slv_req.aw = ax(6, 32'h3000_0000, 0, 3); slv_req.aw_valid = 1'b1;
    slv_req.ar = ax(6, 32'h3000_0000, 0, 3); slv_req.ar_valid = 1'b1;
    #1;
    chk("t6_idle_aw", 64'(slv_resp.aw_ready), 1);
    chk("t6_idle_ar", 64'(slv_resp.ar_ready), 1);
    @(negedge clk); slv_req.aw_valid = 1'b0; slv_req.ar_valid = 1'b0;
    slv_req.w_valid = 1'b1; slv_req.w.last = 1'b1; slv_req.r_ready = 1'b1; slv_req.b_ready = 1'b1;
    #1;
    chk("t6_r_err", 64'(slv_resp.r_valid), 1);
    chk("t6_r_last", 64'(slv_resp.r.last), 1);
    @(negedge clk); slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0;
    #1;
    chk("t6_b_resp", 64'(slv_resp.b.resp), 2);
    chk("t6_r_done", 64'(slv_resp.r_valid), 0);
    @(negedge clk); slv_req.b_ready = 1'b0;
    slv_req.ar = ax(6, 32'h0, 0, 0); slv_req.ar_valid = 1'b1;
    #1 chk("t6_ar2", 64'(slv_resp.ar_ready), 1);
    @(negedge clk); slv_req.ar_valid = 1'b0;
    #1;
    chk("t6_ar2_r", 64'(slv_resp.r_valid), 1);
    chk("t6_err_cnt", 64'(err_cnt), CNT_EN ? 64'd3 : 64'd0);
    @(negedge clk); slv_req.r_ready = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
